// File: rtl/wb_interconnect_pkg.sv
// rtl/wb_interconnect_pkg.sv - shared types and helpers for the Wishbone interconnect
package wb_interconnect_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;
  localparam int OUTSTANDING_W          = 8;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - registered round-robin arbiter searching upward from last_i+1
module rr_arbiter
  import wb_interconnect_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [IDX_W-1:0]   grant_o,
  output logic               valid_o
);

  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;
  logic             found;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic             valid_q, valid_d;

  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(last_i) + off) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    grant_d = grant_q;
    valid_d = valid_q;
    if (load_i) begin
      valid_d = found;
      if (found) grant_d = winner;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_q <= '0;
      valid_q <= 1'b0;
    end else begin
      grant_q <= grant_d;
      valid_q <= valid_d;
    end
  end

  assign grant_o = grant_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/wishbone_rr_multi_controller_device.sv
// rtl/wishbone_rr_multi_controller_device.sv - N-controller to one-device Wishbone arbiter with watchdog
module wishbone_rr_multi_controller_device
  import wb_interconnect_pkg::*;
#(
  parameter int NUM_CONTROLLERS = 4,
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 24,
  parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES,
  localparam int SEL_W = DATA_W / 8,
  localparam int IDX_W = (clog2(NUM_CONTROLLERS) < 1) ? 1 : clog2(NUM_CONTROLLERS)
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_ni,
  input  logic [NUM_CONTROLLERS-1:0]        controller_wb_cyc_o,
  input  logic [NUM_CONTROLLERS-1:0]        controller_wb_stb_o,
  input  logic [NUM_CONTROLLERS-1:0]        controller_wb_we_o,
  input  logic [NUM_CONTROLLERS*SEL_W-1:0]  controller_wb_sel_o,
  input  logic [NUM_CONTROLLERS*DATA_W-1:0] controller_wb_data_o,
  input  logic [NUM_CONTROLLERS*ADDR_W-1:0] controller_wb_adr_o,
  output logic [NUM_CONTROLLERS-1:0]        controller_wb_ack_i,
  output logic [NUM_CONTROLLERS-1:0]        controller_wb_stall_i,
  output logic [NUM_CONTROLLERS-1:0]        controller_wb_error_i,
  output logic [DATA_W-1:0]             controller_wb_data_i,
  output logic                          device_cyc_i,
  output logic                          device_stb_i,
  output logic                          device_we_i,
  output logic [SEL_W-1:0]              device_sel_i,
  output logic [DATA_W-1:0]             device_data_i,
  output logic [ADDR_W-1:0]             device_adr_i,
  input  logic                          device_ack_o,
  input  logic                          device_stall_o,
  input  logic                          device_error_o,
  input  logic [DATA_W-1:0]             device_data_o,
  output logic [IDX_W-1:0]              probe_currentController,
  output logic                          probe_busy,
  output logic                          probe_timeout
);

  localparam int WD_W = (clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  arb_state_e               state_q, state_d;
  logic [IDX_W-1:0]         last_grant_q, last_grant_d;
  logic [WD_W-1:0]          wd_q, wd_d;
  logic [OUTSTANDING_W-1:0] outst_q, outst_d;
  logic [IDX_W-1:0]         grant;
  logic                     arb_valid;
  logic                     in_busy, gnt_cyc, gnt_stb;
  logic                     dev_resp, accept, wd_expire;

  rr_arbiter #(.NUM_REQ(NUM_CONTROLLERS)) u_arbiter (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_ni),
    .load_i  (state_q == IDLE),
    .req_i   (controller_wb_cyc_o),
    .last_i  (last_grant_q),
    .grant_o (grant),
    .valid_o (arb_valid)
  );

  assign gnt_cyc       = controller_wb_cyc_o[grant];
  assign gnt_stb       = controller_wb_stb_o[grant];
  assign in_busy       = (state_q == BUSY) && arb_valid;
  assign device_cyc_i  = in_busy && gnt_cyc;
  assign device_stb_i  = in_busy && gnt_cyc && gnt_stb;
  assign device_we_i   = controller_wb_we_o[grant];
  assign device_sel_i  = controller_wb_sel_o[int'(grant)*SEL_W +: SEL_W];
  assign device_data_i = controller_wb_data_o[int'(grant)*DATA_W +: DATA_W];
  assign device_adr_i  = controller_wb_adr_o[int'(grant)*ADDR_W +: ADDR_W];
  assign controller_wb_data_i = device_data_o;

  assign dev_resp  = device_ack_o || device_error_o;
  assign accept    = device_stb_i && !device_stall_o;
  // A response arriving on the expiry cycle wins, so the transfer completes normally.
  assign wd_expire = (TIMEOUT_CYCLES != 0) && in_busy && gnt_cyc && (wd_q == WD_LIMIT) && !dev_resp;

  always_comb begin
    controller_wb_ack_i   = '0;
    controller_wb_error_i = '0;
    controller_wb_stall_i = '1;
    if (in_busy) begin
      controller_wb_ack_i[grant]   = device_ack_o;
      controller_wb_error_i[grant] = device_error_o || wd_expire;
      controller_wb_stall_i[grant] = device_stall_o;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wd_d         = wd_q;
    outst_d      = outst_q;
    case (state_q)
      IDLE: begin
        wd_d    = '0;
        outst_d = '0;
        if (|controller_wb_cyc_o) state_d = BUSY;
      end
      BUSY: begin
        last_grant_d = grant;
        if (dev_resp) begin
          wd_d = '0;
        end else if ((device_stb_i || (outst_q != '0)) && (wd_q != WD_LIMIT)) begin
          wd_d = wd_q + 1'b1;
        end
        if (accept && !dev_resp && (outst_q != '1)) begin
          outst_d = outst_q + 1'b1;
        end else if (!accept && dev_resp && (outst_q != '0)) begin
          outst_d = outst_q - 1'b1;
        end
        if (!gnt_cyc) state_d = IDLE;
        else if (wd_expire) state_d = ABORT;
      end
      ABORT: begin
        wd_d    = '0;
        outst_d = '0;
        if (!gnt_cyc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_CONTROLLERS - 1);
      wd_q         <= '0;
      outst_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wd_q         <= wd_d;
      outst_q      <= outst_d;
    end
  end

  assign probe_currentController = grant;
  assign probe_busy              = (state_q != IDLE);
  assign probe_timeout           = wd_expire;

endmodule
